// File: rtl/axi4_burst_scheduler.sv
// axi4_burst_scheduler
// Shares one AXI4 master port between a write requester and a read requester.
// Burst commands are arbitrated round-robin and one transaction runs at a time:
// AW -> W -> B for writes, AR -> R for reads.
// Ports:
//   m_axi4_aclk / m_axi4_areset      clock, asynchronous active-high reset
//   m_axi4_aw*/w*/b*                 AXI4 write address, data and response channels
//   m_axi4_ar*/r*                    AXI4 read address and data channels
//   wr_cmd_* / wr_data*              write command handshake and write data stream
//   rd_cmd_* / rd_data*              read command handshake and read data stream
//   wr_done/wr_err, rd_done/rd_err   one-cycle completion pulse with status
// AxSIZE, AxBURST and AxID are constants: size = log2(DW/8), INCR, id 0.
module axi4_burst_scheduler #(
   parameter int C_M00_AXI_ADDR_WIDTH = 32,
   parameter int C_M00_AXI_DATA_WIDTH = 256
) (
   input  logic                              m_axi4_aclk,
   input  logic                              m_axi4_areset,
   output logic                              m_axi4_awvalid,
   input  logic                              m_axi4_awready,
   output logic [C_M00_AXI_ADDR_WIDTH-1:0]   m_axi4_awaddr,
   output logic [7:0]                        m_axi4_awlen,
   output logic [2:0]                        m_axi4_awsize,
   output logic [1:0]                        m_axi4_awburst,
   output logic                              m_axi4_awid,
   output logic                              m_axi4_wvalid,
   input  logic                              m_axi4_wready,
   output logic [C_M00_AXI_DATA_WIDTH-1:0]   m_axi4_wdata,
   output logic                              m_axi4_wlast,
   output logic [C_M00_AXI_DATA_WIDTH/8-1:0] m_axi4_wstrb,
   input  logic                              m_axi4_bvalid,
   output logic                              m_axi4_bready,
   input  logic [1:0]                        m_axi4_bresp,
   output logic                              m_axi4_arvalid,
   input  logic                              m_axi4_arready,
   output logic [C_M00_AXI_ADDR_WIDTH-1:0]   m_axi4_araddr,
   output logic [7:0]                        m_axi4_arlen,
   output logic [2:0]                        m_axi4_arsize,
   output logic [1:0]                        m_axi4_arburst,
   output logic                              m_axi4_arid,
   input  logic                              m_axi4_rvalid,
   output logic                              m_axi4_rready,
   input  logic [C_M00_AXI_DATA_WIDTH-1:0]   m_axi4_rdata,
   input  logic                              m_axi4_rlast,
   input  logic [1:0]                        m_axi4_rresp,
   input  logic                              wr_cmd_valid,
   output logic                              wr_cmd_ready,
   input  logic [C_M00_AXI_ADDR_WIDTH-1:0]   wr_cmd_addr,
   input  logic [7:0]                        wr_cmd_len,
   input  logic                              wr_data_valid,
   output logic                              wr_data_ready,
   input  logic [C_M00_AXI_DATA_WIDTH-1:0]   wr_data,
   input  logic                              rd_cmd_valid,
   output logic                              rd_cmd_ready,
   input  logic [C_M00_AXI_ADDR_WIDTH-1:0]   rd_cmd_addr,
   input  logic [7:0]                        rd_cmd_len,
   output logic                              rd_data_valid,
   input  logic                              rd_data_ready,
   output logic [C_M00_AXI_DATA_WIDTH-1:0]   rd_data,
   output logic                              rd_data_last,
   output logic                              wr_done,
   output logic                              wr_err,
   output logic                              rd_done,
   output logic                              rd_err
);

   localparam int AW   = C_M00_AXI_ADDR_WIDTH;
   localparam int SIZE = $clog2(C_M00_AXI_DATA_WIDTH / 8);

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_AW   = 3'd1;
   localparam logic [2:0] S_W    = 3'd2;
   localparam logic [2:0] S_B    = 3'd3;
   localparam logic [2:0] S_AR   = 3'd4;
   localparam logic [2:0] S_R    = 3'd5;

   logic [2:0]    state_q, state_d;
   logic          last_wr_q, last_wr_d;   // 1: most recent grant went to the write side
   logic [AW-1:0] addr_q, addr_d;
   logic [7:0]    len_q, len_d;
   logic [7:0]    beat_q, beat_d;
   logic          err_q, err_d;
   logic          wr_done_q, wr_done_d, wr_err_q, wr_err_d;
   logic          rd_done_q, rd_done_d, rd_err_q, rd_err_d;
   logic          grant_wr, grant_rd, beat_is_last, w_hs, r_hs, r_beat_err;

   // Commands are never accepted while reset is held, so a requester cannot
   // see a grant that the FSM is unable to record.
   always_comb begin
      grant_wr = 1'b0;
      grant_rd = 1'b0;
      if (state_q == S_IDLE && !m_axi4_areset) begin
         grant_wr = wr_cmd_valid && (!rd_cmd_valid || !last_wr_q);
         grant_rd = rd_cmd_valid && !grant_wr;
      end
   end

   assign wr_cmd_ready   = grant_wr;
   assign rd_cmd_ready   = grant_rd;

   assign m_axi4_awvalid = (state_q == S_AW);
   assign m_axi4_awaddr  = addr_q;
   assign m_axi4_awlen   = len_q;
   assign m_axi4_awsize  = 3'(SIZE);
   assign m_axi4_awburst = 2'b01;
   assign m_axi4_awid    = 1'b0;
   assign m_axi4_arvalid = (state_q == S_AR);
   assign m_axi4_araddr  = addr_q;
   assign m_axi4_arlen   = len_q;
   assign m_axi4_arsize  = 3'(SIZE);
   assign m_axi4_arburst = 2'b01;
   assign m_axi4_arid    = 1'b0;

   assign beat_is_last   = (beat_q == len_q);

   assign m_axi4_wvalid  = (state_q == S_W) && wr_data_valid;
   assign wr_data_ready  = (state_q == S_W) && m_axi4_wready;
   assign m_axi4_wdata   = wr_data;
   assign m_axi4_wlast   = (state_q == S_W) && beat_is_last;
   assign m_axi4_wstrb   = '1;
   assign m_axi4_bready  = (state_q == S_B);

   assign rd_data_valid  = (state_q == S_R) && m_axi4_rvalid;
   assign m_axi4_rready  = (state_q == S_R) && rd_data_ready;
   assign rd_data        = m_axi4_rdata;
   assign rd_data_last   = (state_q == S_R) && m_axi4_rlast;

   assign w_hs           = m_axi4_wvalid && m_axi4_wready;
   assign r_hs           = m_axi4_rvalid && m_axi4_rready;
   // A read beat is bad on an error response or when rlast disagrees with the count.
   assign r_beat_err     = m_axi4_rresp[1] || (m_axi4_rlast != beat_is_last);

   assign wr_done        = wr_done_q;
   assign wr_err         = wr_err_q;
   assign rd_done        = rd_done_q;
   assign rd_err         = rd_err_q;

   always_comb begin
      state_d   = state_q;
      last_wr_d = last_wr_q;
      addr_d    = addr_q;
      len_d     = len_q;
      beat_d    = beat_q;
      err_d     = err_q;
      wr_done_d = 1'b0;
      wr_err_d  = 1'b0;
      rd_done_d = 1'b0;
      rd_err_d  = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (grant_wr) begin
               addr_d    = wr_cmd_addr;
               len_d     = wr_cmd_len;
               last_wr_d = 1'b1;
               beat_d    = 8'd0;
               err_d     = 1'b0;
               state_d   = S_AW;
            end else if (grant_rd) begin
               addr_d    = rd_cmd_addr;
               len_d     = rd_cmd_len;
               last_wr_d = 1'b0;
               beat_d    = 8'd0;
               err_d     = 1'b0;
               state_d   = S_AR;
            end
         end
         S_AW: if (m_axi4_awready) state_d = S_W;
         S_W: begin
            // The counter is not advanced on the final beat, so len 255 never wraps.
            if (w_hs) begin
               if (beat_is_last) state_d = S_B;
               else              beat_d  = beat_q + 8'd1;
            end
         end
         S_B: begin
            if (m_axi4_bvalid) begin
               state_d   = S_IDLE;
               wr_done_d = 1'b1;
               wr_err_d  = m_axi4_bresp[1];
            end
         end
         S_AR: if (m_axi4_arready) state_d = S_R;
         S_R: begin
            if (r_hs) begin
               err_d = err_q || r_beat_err;
               // Saturate if the slave overruns the burst; the error is already latched.
               if (beat_q != 8'hFF) beat_d = beat_q + 8'd1;
               if (m_axi4_rlast) begin
                  state_d   = S_IDLE;
                  rd_done_d = 1'b1;
                  rd_err_d  = err_q || r_beat_err;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge m_axi4_aclk or posedge m_axi4_areset) begin
      if (m_axi4_areset) begin
         state_q   <= S_IDLE;
         last_wr_q <= 1'b0;
         addr_q    <= '0;
         len_q     <= '0;
         beat_q    <= '0;
         err_q     <= 1'b0;
         wr_done_q <= 1'b0;
         wr_err_q  <= 1'b0;
         rd_done_q <= 1'b0;
         rd_err_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         last_wr_q <= last_wr_d;
         addr_q    <= addr_d;
         len_q     <= len_d;
         beat_q    <= beat_d;
         err_q     <= err_d;
         wr_done_q <= wr_done_d;
         wr_err_q  <= wr_err_d;
         rd_done_q <= rd_done_d;
         rd_err_q  <= rd_err_d;
      end
   end

endmodule
